// File: rtl/rvfi_trace_fifo.sv
// RVFI retirement capture FIFO with a valid/ready drain port and sticky
// PC/order continuity checking of every retirement the core reports.
module rvfi_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_halt,
  input  logic                     rvfi_intr,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_pc_wdata,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [166:0]             trc_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic                     pc_err,
  output logic                     order_err,
  output logic [31:0]              err_pc,
  output logic                     halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = 167;

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [31:0]      exp_pc_q, exp_pc_d, err_pc_q, err_pc_d;
  logic [63:0]      exp_ord_q, exp_ord_d;
  logic             have_prev_q, have_prev_d;
  logic             pc_err_q, pc_err_d, order_err_q, order_err_d;
  logic             halted_q, halted_d;
  logic [TW-1:0]    mem_q [DEPTH];

  logic full, empty, push, pop, drop, pc_bad, ord_bad;
  logic [TW-1:0] entry;

  assign entry = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_insn, rvfi_pc_rdata,
                  rvfi_pc_wdata, rvfi_rd_wdata, rvfi_order[31:0]};

  // Extra wrap bit on the pointers distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = trc_valid & trc_ready;
  assign push  = rvfi_valid & (!full | pop);
  assign drop  = rvfi_valid & full & !pop;

  assign trc_valid    = !empty;
  assign trc_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level        = wr_ptr_q - rd_ptr_q;
  assign overflow_cnt = ovf_q;
  assign pc_err       = pc_err_q;
  assign order_err    = order_err_q;
  assign err_pc       = err_pc_q;
  assign halted       = halted_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_d       = ovf_q;
    exp_pc_d    = exp_pc_q;
    exp_ord_d   = exp_ord_q;
    have_prev_d = have_prev_q;
    pc_err_d    = pc_err_q;
    order_err_d = order_err_q;
    err_pc_d    = err_pc_q;
    halted_d    = halted_q;
    pc_bad      = 1'b0;
    ord_bad     = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ovf_d       = '0;
      exp_pc_d    = '0;
      exp_ord_d   = '0;
      have_prev_d = 1'b0;
      pc_err_d    = 1'b0;
      order_err_d = 1'b0;
      err_pc_d    = '0;
      halted_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop && ovf_q != {CNT_W{1'b1}}) ovf_d = ovf_q + 1'b1;
      // Checker sees every retirement, including ones the buffer drops.
      if (rvfi_valid) begin
        if (have_prev_q) begin
          pc_bad  = (rvfi_pc_rdata != exp_pc_q) & !rvfi_intr;
          ord_bad = (rvfi_order != exp_ord_q) | halted_q;
          pc_err_d    = pc_err_q | pc_bad;
          order_err_d = order_err_q | ord_bad;
          if (!(pc_err_q | order_err_q) && (pc_bad | ord_bad))
            err_pc_d = rvfi_pc_rdata;
        end
        exp_pc_d    = rvfi_pc_wdata;
        exp_ord_d   = rvfi_order + 64'd1;
        have_prev_d = 1'b1;
        halted_d    = halted_q | rvfi_halt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= '0;
      exp_pc_q    <= '0;
      exp_ord_q   <= '0;
      have_prev_q <= 1'b0;
      pc_err_q    <= 1'b0;
      order_err_q <= 1'b0;
      err_pc_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      exp_pc_q    <= exp_pc_d;
      exp_ord_q   <= exp_ord_d;
      have_prev_q <= have_prev_d;
      pc_err_q    <= pc_err_d;
      order_err_q <= order_err_d;
      err_pc_q    <= err_pc_d;
      halted_q    <= halted_d;
    end
  end

  // Storage needs no reset: nothing is visible unless the pointers say so.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= entry;
  end
endmodule
